// File: rtl/rx_symbol_gearbox_if.sv
// Frame-in / symbol-beat-out bus of the Viterbi receive gearbox.
// The master drives frames in and the sink ready; the slave is the gearbox.
interface rx_symbol_gearbox_if #(
  parameter int FRAME_W      = 16,
  parameter int SYM_PER_BEAT = 2,
  parameter int MAX_N        = 3
);
  logic                          i_frame_valid;
  logic [FRAME_W-1:0]            i_data_frame;
  logic                          i_frame_last;
  logic                          o_frame_ready;
  logic [SYM_PER_BEAT*MAX_N-1:0] o_rx;
  logic                          o_rx_valid;
  logic                          i_rx_ready;
  logic                          o_ood;

  modport master (
    output i_frame_valid, i_data_frame, i_frame_last, i_rx_ready,
    input  o_frame_ready, o_rx, o_rx_valid, o_ood
  );

  modport slave (
    input  i_frame_valid, i_data_frame, i_frame_last, i_rx_ready,
    output o_frame_ready, o_rx, o_rx_valid, o_ood
  );
endinterface

// File: rtl/rx_symbol_gearbox.sv
// Receive-path slicer: packs incoming frames into a left-justified bit buffer
// and emits beats of SYM_PER_BEAT symbols (2 or 3 bits each) to the branch-metric unit.
module rx_symbol_gearbox #(
  parameter int FRAME_W      = 16,
  parameter int SYM_PER_BEAT = 2,
  parameter int MAX_N        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_s,
  input  logic               i_code_rate,
  rx_symbol_gearbox_if.slave bus
);
  localparam int BUF_W = 2 * FRAME_W;
  localparam int OUT_W = SYM_PER_BEAT * MAX_N;
  localparam int CNT_W = $clog2(BUF_W + 1);

  localparam logic [CNT_W-1:0] B2_LEN    = CNT_W'(SYM_PER_BEAT * 2);
  localparam logic [CNT_W-1:0] B3_LEN    = CNT_W'(SYM_PER_BEAT * 3);
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(BUF_W - FRAME_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   fill_q, fill_d;
  logic               rate_q, rate_d;
  logic [OUT_W-1:0]   rx_q, rx_d;
  logic               rx_valid_q, rx_valid_d;
  logic               ood_q, ood_d;
  logic               ready_q, ready_d;

  logic [OUT_W-1:0]   beat_r2;
  logic [OUT_W-1:0]   beat_r3;
  logic [OUT_W-1:0]   beat_bits;
  logic [CNT_W-1:0]   beat_len;
  logic               accept;
  logic               handshake;
  logic               load;
  logic [BUF_W-1:0]   buf_shift;
  logic [CNT_W-1:0]   rem;
  logic [BUF_W-1:0]   frame_ext;

  // The oldest bit sits at buf_q[BUF_W-1]; symbol gj, bit gb is stream bit gj*n+gb.
  for (genvar gi = 0; gi < SYM_PER_BEAT; gi++) begin : g_sym
    for (genvar gb = 0; gb < MAX_N; gb++) begin : g_bit
      if (gb < 2) begin : g_r2_used
        assign beat_r2[gi*MAX_N+gb] = buf_q[BUF_W-1-(gi*2+gb)];
      end else begin : g_r2_pad
        assign beat_r2[gi*MAX_N+gb] = 1'b0;
      end
      if (gb < 3) begin : g_r3_used
        assign beat_r3[gi*MAX_N+gb] = buf_q[BUF_W-1-(gi*3+gb)];
      end else begin : g_r3_pad
        assign beat_r3[gi*MAX_N+gb] = 1'b0;
      end
    end
  end

  assign beat_bits = rate_q ? beat_r3 : beat_r2;
  assign beat_len  = rate_q ? B3_LEN : B2_LEN;

  always_comb begin
    accept     = bus.o_frame_ready & bus.i_frame_valid;
    handshake  = en_s & rx_valid_q & bus.i_rx_ready;
    load       = en_s & (fill_q >= beat_len) & (~rx_valid_q | bus.i_rx_ready);

    buf_shift  = load ? (buf_q << beat_len) : buf_q;
    rem        = load ? (fill_q - beat_len) : fill_q;
    frame_ext  = {bus.i_data_frame, {(BUF_W-FRAME_W){1'b0}}} >> rem;

    buf_d      = accept ? (buf_shift | frame_ext) : buf_shift;
    fill_d     = accept ? (rem + FRAME_LEN) : rem;
    rx_d       = load ? beat_bits : rx_q;
    rx_valid_d = load ? 1'b1 : (handshake ? 1'b0 : rx_valid_q);
    rate_d     = rate_q;
    state_d    = state_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rate_d  = i_code_rate;
          state_d = bus.i_frame_last ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && bus.i_frame_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leftover bits that cannot form a full beat are dropped here.
        if (en_s && (fill_q < beat_len) && !rx_valid_q) begin
          state_d = ST_DONE;
          buf_d   = '0;
          fill_d  = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ood_d   = (state_d == ST_DONE);
    ready_d = ((state_d == ST_IDLE) || (state_d == ST_RUN)) && (fill_d <= READY_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      fill_q     <= '0;
      rate_q     <= 1'b0;
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
      ood_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      rate_q     <= rate_d;
      rx_q       <= rx_d;
      rx_valid_q <= rx_valid_d;
      ood_q      <= ood_d;
      ready_q    <= ready_d;
    end
  end

  // Ready comes from registered state only, so there is no path from i_rx_ready.
  assign bus.o_frame_ready = en_s & ready_q;
  assign bus.o_rx          = rx_q;
  assign bus.o_rx_valid    = rx_valid_q;
  assign bus.o_ood         = ood_q;
endmodule

// File: tb/tb_rx_symbol_gearbox.sv
// Randomized bench for rx_symbol_gearbox against a bit-queue reference model.
// Each observed beat is compared with the oldest bits of the reference stream.
module tb_rx_symbol_gearbox;
  localparam int FRAME_W      = 16;
  localparam int SYM_PER_BEAT = 2;
  localparam int MAX_N        = 3;
  localparam int OUT_W        = SYM_PER_BEAT * MAX_N;
  localparam int NEVER        = 1000000;

  logic clk = 1'b0;
  logic rst;
  logic en_s;
  logic i_code_rate;

  rx_symbol_gearbox_if #(
    .FRAME_W(FRAME_W), .SYM_PER_BEAT(SYM_PER_BEAT), .MAX_N(MAX_N)
  ) bus ();

  rx_symbol_gearbox #(
    .FRAME_W(FRAME_W), .SYM_PER_BEAT(SYM_PER_BEAT), .MAX_N(MAX_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_s       (en_s),
    .i_code_rate(i_code_rate),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: received bits not yet handed off, in stream order.
  bit bit_q[$];
  bit m_rate;
  bit m_idle;
  bit m_last;
  bit m_ood;
  int ood_timer;
  bit prev_en;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sym_bits();
    return m_rate ? 3 : 2;
  endfunction

  function automatic logic [OUT_W-1:0] exp_beat();
    logic [OUT_W-1:0] r;
    int n;
    r = '0;
    n = sym_bits();
    for (int j = 0; j < SYM_PER_BEAT; j++)
      for (int i = 0; i < n; i++)
        r[j*MAX_N+i] = bit_q[j*n+i];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst               = 1'b1;
    en_s              = 1'b1;
    i_code_rate       = 1'b0;
    bus.i_frame_valid = 1'b0;
    bus.i_data_frame  = '0;
    bus.i_frame_last  = 1'b0;
    bus.i_rx_ready    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_val("rst_rx", 32'(bus.o_rx), 0);
    chk_val("rst_rx_valid", 32'(bus.o_rx_valid), 0);
    chk_val("rst_ood", 32'(bus.o_ood), 0);
    chk_val("rst_frame_ready", 32'(bus.o_frame_ready), 0);
    bit_q.delete();
    m_rate    = 1'b0;
    m_idle    = 1'b1;
    m_last    = 1'b0;
    m_ood     = 1'b0;
    ood_timer = 0;
    prev_en   = 1'b1;
  endtask

  task automatic run_stream(input string name, input bit rate, input int nframes,
                            input bit rand_data, input logic [FRAME_W-1:0] fixed,
                            input int rdy_pct, input int valid_pct, input int en_pct,
                            input int stall_until, input int en_off_at, input int abort_at);
    int sent       = 0;
    int cyc        = 0;
    int first_acc  = -1;
    int first_hs   = -1;
    int last_hs    = -1;
    int done_cyc   = 0;
    int beat_cnt   = 0;
    int total_bits = 0;
    int blen;
    bit acc;
    bit hs;
    bit aborted    = 1'b0;

    do_reset();
    while (1) begin
      @(negedge clk);
      if (ood_timer > 0 && prev_en) begin
        ood_timer--;
        if (ood_timer == 0) m_ood = 1'b1;
      end
      en_s = (cyc >= en_off_at && cyc < en_off_at + 3) ? 1'b0
             : ($urandom_range(99) < en_pct);
      bus.i_rx_ready    = (cyc < stall_until) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      bus.i_frame_valid = (sent < nframes) && ($urandom_range(99) < valid_pct);
      bus.i_data_frame  = rand_data ? FRAME_W'($urandom) : fixed;
      bus.i_frame_last  = (sent == nframes - 1);
      i_code_rate       = m_idle ? rate : 1'($urandom);
      #1;
      blen = SYM_PER_BEAT * sym_bits();

      chk_val("ood", 32'(bus.o_ood), 32'(m_ood));
      if (m_ood) chk_val("done_rx_valid", 32'(bus.o_rx_valid), 0);
      if (m_last) chk_val("ready_after_last", 32'(bus.o_frame_ready), 0);
      if (!en_s) chk_val("en_low_ready", 32'(bus.o_frame_ready), 0);
      if (bit_q.size() > FRAME_W + blen) chk_val("ready_full", 32'(bus.o_frame_ready), 0);

      if (bus.o_rx_valid) begin
        if (bit_q.size() < blen) chk_val("beat_underrun", 32'(bit_q.size()), 32'(blen));
        else chk_val("beat_data", 32'(bus.o_rx), 32'(exp_beat()));
      end

      acc = en_s & bus.i_frame_valid & bus.o_frame_ready;
      hs  = en_s & bus.o_rx_valid & bus.i_rx_ready;

      if (hs) begin
        $display("%s beat %0d rx=0x%02h", name, beat_cnt, bus.o_rx);
        for (int k = 0; k < blen && bit_q.size() > 0; k++) void'(bit_q.pop_front());
        beat_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (acc) begin
        if (m_idle) begin
          m_rate = i_code_rate;
          m_idle = 1'b0;
        end
        for (int b = FRAME_W - 1; b >= 0; b--) bit_q.push_back(bus.i_data_frame[b]);
        if (bus.i_frame_last) m_last = 1'b1;
        total_bits += FRAME_W;
        sent++;
        if (first_acc < 0) first_acc = cyc;
      end
      blen = SYM_PER_BEAT * sym_bits();
      if (hs && m_last && bit_q.size() < blen && ood_timer == 0 && !m_ood) ood_timer = 2;

      prev_en = en_s;
      if (m_ood) done_cyc++;
      cyc++;
      if (abort_at >= 0 && cyc == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (done_cyc == 3) break;
      if (cyc >= 2000) begin
        chk_val("timeout_ood", 32'(bus.o_ood), 1);
        break;
      end
    end

    if (!aborted) begin
      chk_val("beat_count", 32'(beat_cnt), 32'(total_bits / blen));
      if (rdy_pct == 100 && valid_pct == 100 && en_pct == 100 &&
          stall_until == 0 && en_off_at == NEVER) begin
        chk_val("no_gaps", 32'(last_hs - first_hs + 1), 32'(beat_cnt));
        chk_val("latency", 32'(first_hs - first_acc), 2);
      end
    end
  endtask

  initial begin
    rst               = 1'b1;
    en_s              = 1'b0;
    i_code_rate       = 1'b0;
    bus.i_frame_valid = 1'b0;
    bus.i_data_frame  = '0;
    bus.i_frame_last  = 1'b0;
    bus.i_rx_ready    = 1'b0;

    run_stream("r2_a5c3",      1'b0, 1, 1'b0, 16'hA5C3, 100, 100, 100, 0, NEVER, -1);
    run_stream("r3_ffff_x3",   1'b1, 3, 1'b0, 16'hFFFF, 100, 100, 100, 0, NEVER, -1);
    run_stream("r3_ffff_x1",   1'b1, 1, 1'b0, 16'hFFFF, 100, 100, 100, 0, NEVER, -1);
    run_stream("r2_stall",     1'b0, 4, 1'b1, 16'h0000, 100, 100, 100, 8, NEVER, -1);
    run_stream("r2_abort",     1'b0, 8, 1'b1, 16'h0000, 100, 100, 100, 0, 6, 14);
    run_stream("r3_after_rst", 1'b1, 4, 1'b1, 16'h0000, 70, 80, 90, 0, NEVER, -1);
    for (int s = 0; s < 8; s++) begin
      run_stream("rand", 1'($urandom), $urandom_range(6, 1), 1'b1, 16'h0000,
                 $urandom_range(100, 40), $urandom_range(100, 50),
                 $urandom_range(100, 60), $urandom_range(6, 0), NEVER, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end
endmodule
